// File: rtl/dma_priority_arbiter_if.sv
// Bus bundle for dma_priority_arbiter: channel requests, CPU hold handshake and
// grant outputs. The arbiter connects through the slave modport; the
// requester/CPU side connects through the master modport.
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic       rotatePriority;
    logic       HLDA;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       busy;

    modport master (
        output DREQ, maskReg, rotatePriority, HLDA, transferDone,
        input  HRQ, DACK, activeChannel, busy
    );

    modport slave (
        input  DREQ, maskReg, rotatePriority, HLDA, transferDone,
        output HRQ, DACK, activeChannel, busy
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: four-channel DMA request arbiter with a CPU hold
// handshake (HRQ/HLDA) and a one-hot grant (DACK). The FSM is one-hot with the
// states IDLE, WAIT_HLDA, GRANT and RELEASE. All outputs are registered and are
// computed from the next state, so they change on the edge where the FSM moves.
// Optional feature: define DMA_ROTATING_PRIORITY_EN to enable rotating priority
// (the serviced channel becomes lowest). Without it, priority is fixed with
// channel 0 highest, and rotatePriority is ignored.
module dma_priority_arbiter (
    input  logic                    CLK,
    input  logic                    RESET,
    dma_priority_arbiter_if.slave   bus
);
    localparam logic [3:0] ST_IDLE      = 4'b0001;
    localparam logic [3:0] ST_WAIT_HLDA = 4'b0010;
    localparam logic [3:0] ST_GRANT     = 4'b0100;
    localparam logic [3:0] ST_RELEASE   = 4'b1000;

    logic [3:0] state_r;
    logic [3:0] state_nxt_s;
    logic [1:0] active_r;
    logic [1:0] active_nxt_s;
    logic       hrq_r;
    logic [3:0] dack_r;
    logic       busy_r;

    logic [3:0] valid_s;
    logic       any_valid_s;
    logic [1:0] winner_s;
    logic [1:0] eff_ptr_s;
    logic       grant_exit_s;

    // Returns the first valid channel, searching upward from ptr and wrapping.
    function automatic logic [1:0] pick_channel(input logic [3:0] valid,
                                                input logic [1:0] ptr);
        logic [1:0] idx;
        pick_channel = ptr;
        // Walk from the lowest priority to the highest so that the
        // highest-priority valid channel is the last one written.
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (valid[idx]) begin
                pick_channel = idx;
            end
        end
    endfunction

    // Decodes a channel index into the one-hot acknowledge pattern.
    function automatic logic [3:0] dack_decode(input logic [1:0] ch);
        dack_decode = 4'b0001 << ch;
    endfunction

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [1:0] ptr_r;

    // Priority pointer: after each service the next channel up becomes the
    // highest priority. It falls back to channel 0 whenever fixed mode is selected.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_r <= 2'd0;
        end else if (!bus.rotatePriority) begin
            ptr_r <= 2'd0;
        end else if (state_r == ST_RELEASE) begin
            ptr_r <= active_r + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign eff_ptr_s = bus.rotatePriority ? ptr_r : 2'd0;
`else
    logic unused_rotate_s;
    assign unused_rotate_s = bus.rotatePriority;
    assign eff_ptr_s       = 2'd0;
`endif

    // Arbitration and next-state logic.
    always_comb begin
        valid_s      = bus.DREQ & ~bus.maskReg;
        any_valid_s  = |valid_s;
        winner_s     = pick_channel(valid_s, eff_ptr_s);
        grant_exit_s = bus.transferDone | ~bus.DREQ[active_r] |
                       bus.maskReg[active_r] | ~bus.HLDA;
        state_nxt_s  = state_r;
        active_nxt_s = active_r;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s  = ST_WAIT_HLDA;
                    active_nxt_s = winner_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_WAIT_HLDA: begin
                // A higher-priority request can still replace the pending
                // channel, up to and including the cycle in which HLDA arrives.
                if (!any_valid_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.HLDA) begin
                    state_nxt_s  = ST_GRANT;
                    active_nxt_s = winner_s;
                end else begin
                    state_nxt_s  = ST_WAIT_HLDA;
                    active_nxt_s = winner_s;
                end
            end
            ST_GRANT: begin
                if (grant_exit_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                // Any illegal one-hot encoding returns the FSM to IDLE.
                state_nxt_s  = ST_IDLE;
                active_nxt_s = 2'd0;
            end
        endcase
    end

    // State register and registered outputs, derived from the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= ST_IDLE;
            active_r <= 2'd0;
            hrq_r    <= 1'b0;
            dack_r   <= 4'b0000;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            active_r <= active_nxt_s;
            hrq_r    <= (state_nxt_s == ST_WAIT_HLDA) || (state_nxt_s == ST_GRANT);
            dack_r   <= (state_nxt_s == ST_GRANT) ? dack_decode(active_nxt_s) : 4'b0000;
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.HRQ           = hrq_r;
    assign bus.DACK          = dack_r;
    assign bus.activeChannel = active_r;
    assign bus.busy          = busy_r;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed testbench for dma_priority_arbiter. Expected values are worked out
// by hand from the cycle behaviour of the arbiter. Inputs are driven, and
// outputs sampled, 1 time unit after each rising clock edge.
module tb_dma_priority_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    dma_priority_arbiter_if bus_if ();

    dma_priority_arbiter dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.DREQ         = 4'b0000;
        bus_if.maskReg      = 4'b0000;
        bus_if.HLDA         = 1'b0;
        bus_if.transferDone = 1'b0;
    endtask

    // Runs one full service from IDLE with the current DREQ and returns the
    // grant that was observed.
    task automatic run_service(output logic [3:0] dack_seen, output logic [1:0] ch_seen);
        tick();                          // IDLE -> WAIT_HLDA
        bus_if.HLDA = 1'b1;
        tick();                          // WAIT_HLDA -> GRANT
        dack_seen = bus_if.DACK;
        ch_seen   = bus_if.activeChannel;
        bus_if.transferDone = 1'b1;
        tick();                          // GRANT -> RELEASE
        bus_if.transferDone = 1'b0;
        bus_if.HLDA         = 1'b0;
        tick();                          // RELEASE -> IDLE
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus_if.rotatePriority = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.DACK, bus_if.activeChannel, bus_if.busy} !== 8'b0_0000_00_0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b",
                     {bus_if.HRQ, bus_if.DACK, bus_if.activeChannel, bus_if.busy}, 8'b0_0000_00_0);
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed_grant();
        bus_if.rotatePriority = 1'b0;
        bus_if.DREQ = 4'b0101;
        tick();                                   // t+1
        vectors++;
        if ({bus_if.HRQ, bus_if.busy, bus_if.DACK} !== 6'b11_0000) begin
            miscompares++;
            $display("FAIL fixed_hrq: got %b want %b", {bus_if.HRQ, bus_if.busy, bus_if.DACK}, 6'b11_0000);
        end
        tick();                                   // t+2
        tick();                                   // t+3
        vectors++;
        if (bus_if.HRQ !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_hrq_hold: got %b want %b", bus_if.HRQ, 1'b1);
        end
        bus_if.HLDA = 1'b1;
        tick();                                   // t+4
        vectors++;
        if ({bus_if.DACK, bus_if.activeChannel} !== 6'b0001_00) begin
            miscompares++;
            $display("FAIL fixed_dack: got %b want %b", {bus_if.DACK, bus_if.activeChannel}, 6'b0001_00);
        end
        bus_if.transferDone = 1'b1;
        bus_if.DREQ = 4'b0000;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.DACK, bus_if.busy} !== 6'b0_0000_1) begin
            miscompares++;
            $display("FAIL fixed_release: got %b want %b", {bus_if.HRQ, bus_if.DACK, bus_if.busy}, 6'b0_0000_1);
        end
        idle_inputs();
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL fixed_idle: got %b want %b", {bus_if.HRQ, bus_if.busy}, 2'b00);
        end
    endtask

    task automatic test_preempt_wait();
        bus_if.DREQ = 4'b0100;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.activeChannel} !== 3'b1_10) begin
            miscompares++;
            $display("FAIL preempt_pending2: got %b want %b", {bus_if.HRQ, bus_if.activeChannel}, 3'b1_10);
        end
        bus_if.DREQ = 4'b0101;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.activeChannel} !== 3'b1_00) begin
            miscompares++;
            $display("FAIL preempt_pending0: got %b want %b", {bus_if.HRQ, bus_if.activeChannel}, 3'b1_00);
        end
        bus_if.HLDA = 1'b1;
        tick();
        vectors++;
        if ({bus_if.DACK, bus_if.activeChannel} !== 6'b0001_00) begin
            miscompares++;
            $display("FAIL preempt_dack: got %b want %b", {bus_if.DACK, bus_if.activeChannel}, 6'b0001_00);
        end
        bus_if.DREQ = 4'b0000;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_wait_cancel();
        bus_if.DREQ = 4'b0100;
        tick();
        // transferDone outside GRANT must have no effect
        bus_if.transferDone = 1'b1;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.busy, bus_if.DACK} !== 6'b11_0000) begin
            miscompares++;
            $display("FAIL wait_td_ignored: got %b want %b", {bus_if.HRQ, bus_if.busy, bus_if.DACK}, 6'b11_0000);
        end
        bus_if.transferDone = 1'b0;
        bus_if.DREQ = 4'b0000;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL wait_cancel: got %b want %b", {bus_if.HRQ, bus_if.busy}, 2'b00);
        end
    endtask

    task automatic test_simultaneous_exit();
        bus_if.DREQ = 4'b1000;
        tick();
        bus_if.HLDA = 1'b1;
        tick();
        vectors++;
        if ({bus_if.DACK, bus_if.activeChannel} !== 6'b1000_11) begin
            miscompares++;
            $display("FAIL simul_grant3: got %b want %b", {bus_if.DACK, bus_if.activeChannel}, 6'b1000_11);
        end
        bus_if.transferDone = 1'b1;
        bus_if.HLDA = 1'b0;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.DACK, bus_if.busy} !== 6'b0_0000_1) begin
            miscompares++;
            $display("FAIL simul_release: got %b want %b", {bus_if.HRQ, bus_if.DACK, bus_if.busy}, 6'b0_0000_1);
        end
        bus_if.transferDone = 1'b0;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.DACK, bus_if.busy} !== 6'b0_0000_0) begin
            miscompares++;
            $display("FAIL simul_idle: got %b want %b", {bus_if.HRQ, bus_if.DACK, bus_if.busy}, 6'b0_0000_0);
        end
        // The request is still high, so the next edge arbitrates again.
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.activeChannel} !== 3'b1_11) begin
            miscompares++;
            $display("FAIL simul_rerequest: got %b want %b", {bus_if.HRQ, bus_if.activeChannel}, 3'b1_11);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mask();
        bus_if.DREQ    = 4'b0010;
        bus_if.maskReg = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus_if.HRQ, bus_if.busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL mask_ignored[%0d]: got %b want %b", i, {bus_if.HRQ, bus_if.busy}, 2'b00);
            end
        end
        bus_if.maskReg = 4'b0000;
        tick();
        bus_if.HLDA = 1'b1;
        tick();
        vectors++;
        if (bus_if.DACK !== 4'b0010) begin
            miscompares++;
            $display("FAIL mask_grant1: got %b want %b", bus_if.DACK, 4'b0010);
        end
        bus_if.maskReg = 4'b0010;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.DACK, bus_if.busy} !== 6'b0_0000_1) begin
            miscompares++;
            $display("FAIL mask_release: got %b want %b", {bus_if.HRQ, bus_if.DACK, bus_if.busy}, 6'b0_0000_1);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_rotation();
        logic [3:0] d;
        logic [1:0] c;
        logic [3:0] exp_d [3];
`ifdef DMA_ROTATING_PRIORITY_EN
        exp_d[0] = 4'b0100;
        exp_d[1] = 4'b1000;
        exp_d[2] = 4'b0001;
`else
        exp_d[0] = 4'b0001;
        exp_d[1] = 4'b0001;
        exp_d[2] = 4'b0001;
`endif
        bus_if.rotatePriority = 1'b1;
        bus_if.DREQ = 4'b0010;
        run_service(d, c);
        vectors++;
        if (d !== 4'b0010) begin
            miscompares++;
            $display("FAIL rotate_first: got %b want %b", d, 4'b0010);
        end
        bus_if.DREQ = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            run_service(d, c);
            vectors++;
            if (d !== exp_d[i]) begin
                miscompares++;
                $display("FAIL rotate_seq[%0d]: got %b want %b", i, d, exp_d[i]);
            end
        end
        // Service ch1 so the pointer moves to 2, then drop to fixed mode.
        bus_if.DREQ = 4'b0010;
        run_service(d, c);
        bus_if.rotatePriority = 1'b0;
        bus_if.DREQ = 4'b1111;
        run_service(d, c);
        vectors++;
        if (d !== 4'b0001) begin
            miscompares++;
            $display("FAIL rotate_off_fixed: got %b want %b", d, 4'b0001);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        bus_if.rotatePriority = 1'b1;
        bus_if.DREQ = 4'b0010;
        tick();
        bus_if.HLDA = 1'b1;
        tick();
        vectors++;
        if (bus_if.DACK !== 4'b0010) begin
            miscompares++;
            $display("FAIL rstgrant_grant1: got %b want %b", bus_if.DACK, 4'b0010);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.DACK, bus_if.activeChannel, bus_if.busy} !== 8'b0_0000_00_0) begin
            miscompares++;
            $display("FAIL rstgrant_outputs: got %b want %b",
                     {bus_if.HRQ, bus_if.DACK, bus_if.activeChannel, bus_if.busy}, 8'b0_0000_00_0);
        end
        rst = 1'b0;
        bus_if.HLDA = 1'b0;
        bus_if.DREQ = 4'b1111;
        tick();
        vectors++;
        if ({bus_if.HRQ, bus_if.activeChannel} !== 3'b1_00) begin
            miscompares++;
            $display("FAIL rstgrant_order: got %b want %b", {bus_if.HRQ, bus_if.activeChannel}, 3'b1_00);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        idle_inputs();
        bus_if.rotatePriority = 1'b0;
        test_reset();
        test_fixed_grant();
        test_preempt_wait();
        test_wait_cancel();
        test_simultaneous_exit();
        test_mask();
        test_rotation();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
